// File: rtl/program_counter_if.sv
// program_counter_if
//   Control and address bundle between the decoder/ALU side (master) and the
//   fetch-stage program counter (slave).
//
//   Signals:
//     stall           master->slave  hold addr, stack and flags this cycle
//     jump            master->slave  load addr with target
//     branch          master->slave  conditional relative branch request
//     branch_taken    master->slave  branch condition, used only with branch
//     call            master->slave  push addr+1, load addr with target
//     ret             master->slave  pop return address into addr
//     target          master->slave  absolute jump/call target
//     offset          master->slave  two's-complement branch offset
//     addr            slave->master  current instruction address
//     stack_depth     slave->master  occupied return-stack entries
//     stack_overflow  slave->master  sticky: call seen with stack full
//     stack_underflow slave->master  sticky: ret seen with stack empty
interface program_counter_if #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                  stall;
    logic                  jump;
    logic                  branch;
    logic                  branch_taken;
    logic                  call;
    logic                  ret;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DEPTH_W-1:0]    stack_depth;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output stall,
        output jump,
        output branch,
        output branch_taken,
        output call,
        output ret,
        output target,
        output offset,
        input  addr,
        input  stack_depth,
        input  stack_overflow,
        input  stack_underflow
    );

    modport slave (
        input  stall,
        input  jump,
        input  branch,
        input  branch_taken,
        input  call,
        input  ret,
        input  target,
        input  offset,
        output addr,
        output stack_depth,
        output stack_overflow,
        output stack_underflow
    );
endinterface

// File: rtl/program_counter.sv
// program_counter
//   Fetch-stage address generator. Holds the current instruction address and
//   each cycle advances it by increment, jump, PC-relative branch, call or
//   return. Calls/returns use an internal LIFO return stack with sticky
//   overflow/underflow flags. All outputs are registers.
//
//   Ports:
//     clk     system clock, all state changes on the rising edge
//     rst     synchronous active-high reset
//     pc_bus  program_counter_if slave modport (controls in, addr/status out)
//
//   Next-address priority, highest first:
//     rst, stall, ret, call, jump, branch && branch_taken, increment.
module program_counter #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    program_counter_if.slave      pc_bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_seq;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  push;

    // Sequential successor; wraps naturally at 2^ADDR_WIDTH.
    assign addr_seq    = addr_q + ADDR_WIDTH'(1);
    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);

    // Entry below the occupancy pointer is the top of stack.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    always_comb begin
        addr_d  = addr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;

        if (!pc_bus.stall) begin
            if (pc_bus.ret) begin
                if (!stack_empty) begin
                    addr_d  = stack_top;
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    // Empty-stack return degrades to a plain increment.
                    addr_d = addr_seq;
                    unf_d  = 1'b1;
                end
            end else if (pc_bus.call) begin
                // The redirect happens even when the push is dropped.
                addr_d = pc_bus.target;
                if (!stack_full) begin
                    push    = 1'b1;
                    depth_d = depth_q + DEPTH_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (pc_bus.jump) begin
                addr_d = pc_bus.target;
            end else if (pc_bus.branch && pc_bus.branch_taken) begin
                // Offset is already ADDR_WIDTH wide, so a modular add equals
                // adding the sign-extended value.
                addr_d = addr_q + pc_bus.offset;
            end else begin
                addr_d = addr_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage carries no reset; entries above depth_q are don't-care.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (!rst && push && (depth_q == DEPTH_W'(i))) begin
                stack_q[i] <= addr_seq;
            end
        end
    end

    assign pc_bus.addr            = addr_q;
    assign pc_bus.stack_depth     = depth_q;
    assign pc_bus.stack_overflow  = ovf_q;
    assign pc_bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter
//   Directed scenarios plus randomized control traffic, every cycle compared
//   against a behavioural model holding the address as an integer and the
//   return stack as a queue.
module tb_program_counter;
    localparam int unsigned AW = 4;
    localparam int unsigned SD = 4;
    localparam int          MOD = 1 << AW;

    logic clk;
    logic rst;

    program_counter_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) pc_bus ();

    program_counter #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (pc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference state.
    int m_addr;
    int m_stack[$];
    int m_ovf;
    int m_unf;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of controls, advance the model, compare all outputs.
    task automatic step(input bit r, input bit s, input bit rt, input bit cl, input bit j,
                        input bit b, input bit bt, input int tgt, input int off);
        int soff;
        rst                 = r;
        pc_bus.stall        = s;
        pc_bus.ret          = rt;
        pc_bus.call         = cl;
        pc_bus.jump         = j;
        pc_bus.branch       = b;
        pc_bus.branch_taken = bt;
        pc_bus.target       = AW'(tgt);
        pc_bus.offset       = AW'(off);
        @(posedge clk);
        if (r) begin
            m_addr = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (s) begin
            // hold everything
        end else if (rt) begin
            if (m_stack.size() > 0) begin
                m_addr = m_stack.pop_back();
            end else begin
                m_addr = (m_addr + 1) % MOD;
                m_unf  = 1;
            end
        end else if (cl) begin
            if (m_stack.size() < SD) m_stack.push_back((m_addr + 1) % MOD);
            else m_ovf = 1;
            m_addr = tgt;
        end else if (j) begin
            m_addr = tgt;
        end else if (b && bt) begin
            soff   = (off >= MOD / 2) ? off - MOD : off;
            m_addr = (((m_addr + soff) % MOD) + MOD) % MOD;
        end else begin
            m_addr = (m_addr + 1) % MOD;
        end
        #1;
        check("addr", int'(pc_bus.addr), m_addr);
        check("depth", int'(pc_bus.stack_depth), m_stack.size());
        check("ovf", int'(pc_bus.stack_overflow), m_ovf);
        check("unf", int'(pc_bus.stack_underflow), m_unf);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jmp(input int t);
        step(0, 0, 0, 0, 1, 0, 0, t, 0);
    endtask

    task automatic call_to(input int t);
        step(0, 0, 0, 1, 0, 0, 0, t, 0);
    endtask

    task automatic do_ret();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_addr = 0;
        m_ovf = 0;
        m_unf = 0;
        rst = 1'b1;
        pc_bus.stall = 0; pc_bus.ret = 0; pc_bus.call = 0; pc_bus.jump = 0;
        pc_bus.branch = 0; pc_bus.branch_taken = 0; pc_bus.target = '0; pc_bus.offset = '0;

        // Reset with other requests active: reset must win.
        step(1, 0, 1, 1, 1, 1, 1, 9, 3);
        check("rst_addr", int'(pc_bus.addr), 0);

        // Free run wraps 15 -> 0.
        for (int i = 0; i < 16; i++) idle();
        check("wrap_addr", int'(pc_bus.addr), 0);

        // Branches.
        jmp(5);
        step(0, 0, 0, 0, 0, 1, 1, 0, 4'hE);
        check("br_back", int'(pc_bus.addr), 3);
        jmp(5);
        step(0, 0, 0, 0, 0, 1, 0, 0, 4'hE);
        check("br_not_taken", int'(pc_bus.addr), 6);
        jmp(14);
        step(0, 0, 0, 0, 0, 1, 1, 0, 3);
        check("br_wrap", int'(pc_bus.addr), 1);

        // Nested call/return.
        jmp(2);
        call_to(9);
        check("call1", int'(pc_bus.addr), 9);
        call_to(12);
        check("call2_depth", int'(pc_bus.stack_depth), 2);
        do_ret();
        check("ret1", int'(pc_bus.addr), 10);
        do_ret();
        check("ret2", int'(pc_bus.addr), 3);

        // Overflow then underflow.
        for (int i = 1; i <= 5; i++) call_to(i);
        check("ovf_addr", int'(pc_bus.addr), 5);
        check("ovf_depth", int'(pc_bus.stack_depth), 4);
        check("ovf_flag", int'(pc_bus.stack_overflow), 1);
        for (int i = 0; i < 4; i++) do_ret();
        check("ret_last", int'(pc_bus.addr), 4);
        do_ret();
        check("unf_addr", int'(pc_bus.addr), 5);
        check("unf_flag", int'(pc_bus.stack_underflow), 1);

        // Stall holds; ret beats call and jump.
        jmp(7);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        check("stall_addr", int'(pc_bus.addr), 7);
        check("stall_depth", int'(pc_bus.stack_depth), 0);
        call_to(3);
        step(0, 0, 1, 1, 1, 0, 0, 0, 0);
        check("ret_wins", int'(pc_bus.addr), 8);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        check("stall_no_flag", int'(pc_bus.addr), 8);

        // Reset with depth 2 and overflow set.
        call_to(1);
        call_to(2);
        check("pre_rst_depth", int'(pc_bus.stack_depth), 2);
        step(1, 0, 0, 1, 0, 0, 0, 4, 0);
        check("rst2_addr", int'(pc_bus.addr), 0);
        check("rst2_depth", int'(pc_bus.stack_depth), 0);
        check("rst2_ovf", int'(pc_bus.stack_overflow), 0);
        check("rst2_unf", int'(pc_bus.stack_underflow), 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)),
                 int'($urandom_range(0, MOD - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
